branch_predictor: RTL and testbench

Parametrised branch target buffer with per-entry 2-bit saturating direction counters, placed in the IF stage of the pipelined 16-bit CPU. It predicts the next PC in the same cycle the instruction memory is read, so taken branches redirect fetch early instead of waiting for EX-stage resolution and flushing IF/ID and ID/EX. The EX stage trains it with the resolved outcome, and it keeps a saturating mispredict performance counter.

---
 rtl/branch_predictor_if.sv | 28 ++
 rtl/branch_predictor.sv | 82 ++++++++
 tb/tb_branch_predictor.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and EX-side training signals of the branch target buffer.
// The master drives the fetch PC and resolved branches; the slave is the predictor.
interface branch_predictor_if #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
);
  logic [ADDR_W-1:0] if_pc;
  logic              pred_hit;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_next_pc;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_mispredict;
  logic              clear;
  logic [CNT_W-1:0]  mispredict_cnt;

  modport master (
    output if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, clear,
    input  pred_hit, pred_taken, pred_next_pc, mispredict_cnt
  );

  modport slave (
    input  if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, clear,
    output pred_hit, pred_taken, pred_next_pc, mispredict_cnt
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters,
// combinational IF-stage lookup, EX-stage training and a saturating mispredict counter.
module branch_predictor #(
  parameter int ADDR_W  = 16,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  branch_predictor_if.slave   bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 1;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [CNT_W-1:0]   mispredCnt_q, mispredCnt_d;

  logic [IDX_W-1:0] lookupIdx, updIdx;
  logic [TAG_W-1:0] lookupTag, updTag;
  logic             lookupHit, lookupTaken, updHit;
  logic [1:0]       updCtr_d;
  logic             unusedPcBit0;

  // PC bit 0 is always zero for 2-byte aligned instructions.
  assign unusedPcBit0 = bus.if_pc[0] ^ bus.upd_pc[0];

  assign lookupIdx = bus.if_pc[IDX_W:1];
  assign lookupTag = bus.if_pc[ADDR_W-1:IDX_W+1];
  assign updIdx    = bus.upd_pc[IDX_W:1];
  assign updTag    = bus.upd_pc[ADDR_W-1:IDX_W+1];

  always_comb begin
    lookupHit   = valid_q[lookupIdx] && (tag_q[lookupIdx] == lookupTag);
    lookupTaken = lookupHit && ctr_q[lookupIdx][1];
    updHit      = valid_q[updIdx] && (tag_q[updIdx] == updTag);
    updCtr_d    = ctr_q[updIdx];
    if (bus.upd_taken) begin
      if (ctr_q[updIdx] != 2'b11) updCtr_d = ctr_q[updIdx] + 2'd1;
    end else begin
      if (ctr_q[updIdx] != 2'b00) updCtr_d = ctr_q[updIdx] - 2'd1;
    end
    mispredCnt_d = mispredCnt_q;
    if (bus.upd_valid && bus.upd_mispredict && (mispredCnt_q != {CNT_W{1'b1}}))
      mispredCnt_d = mispredCnt_q + CNT_W'(1);
  end

  assign bus.pred_hit       = lookupHit;
  assign bus.pred_taken     = lookupTaken;
  assign bus.pred_next_pc   = lookupTaken ? target_q[lookupIdx] : bus.if_pc + ADDR_W'(2);
  assign bus.mispredict_cnt = mispredCnt_q;

  // Clear wins over training, but the mispredict count still advances that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= '0;
      mispredCnt_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else begin
      mispredCnt_q <= mispredCnt_d;
      if (bus.clear) begin
        valid_q <= '0;
      end else if (bus.upd_valid) begin
        if (updHit) begin
          ctr_q[updIdx] <= updCtr_d;
          if (bus.upd_taken) target_q[updIdx] <= bus.upd_target;
        end else if (bus.upd_taken) begin
          valid_q[updIdx]  <= 1'b1;
          tag_q[updIdx]    <= updTag;
          target_q[updIdx] <= bus.upd_target;
          ctr_q[updIdx]    <= 2'b10;
        end
      end
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: allocation, counter saturation, aliasing,
// same-cycle clear/lookup, PC wrap, mispredict saturation and asynchronous reset.
module tb_branch_predictor;
  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  branch_predictor_if #(.ADDR_W(16), .CNT_W(4)) bus ();

  branch_predictor #(.ADDR_W(16), .ENTRIES(16), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [15:0] pc, input logic taken,
                               input logic [15:0] target, input logic mispredict,
                               input logic clr);
    bus.upd_valid      = valid;
    bus.upd_pc         = pc;
    bus.upd_taken      = taken;
    bus.upd_target     = target;
    bus.upd_mispredict = mispredict;
    bus.clear          = clr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic lookup(input string tag, input logic [15:0] pc, input logic hit,
                        input logic taken, input logic [15:0] nextPc);
    bus.if_pc = pc;
    #1;
    checkOutput({tag, "_hit"}, 32'(bus.pred_hit), 32'(hit));
    checkOutput({tag, "_taken"}, 32'(bus.pred_taken), 32'(taken));
    checkOutput({tag, "_next"}, 32'(bus.pred_next_pc), 32'(nextPc));
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    bus.if_pc  = 16'h0010;
    applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    #2;
    lookup("cold", 16'h0010, 1'b0, 1'b0, 16'h0012);
    checkOutput("cold_cnt", 32'(bus.mispredict_cnt), 32'd0);
    #10 rst_n = 1'b1;

    // Allocate 0x0010 -> 0x0040; lookup in the same cycle sees the old state.
    tick();
    applyStimulus(1'b1, 16'h0010, 1'b1, 16'h0040, 1'b0, 1'b0);
    lookup("alloc_same", 16'h0010, 1'b0, 1'b0, 16'h0012);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    lookup("alloc_next", 16'h0010, 1'b1, 1'b1, 16'h0040);

    // Not-taken miss does not allocate.
    applyStimulus(1'b1, 16'h0020, 1'b0, 16'h0080, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    lookup("nt_miss", 16'h0020, 1'b0, 1'b0, 16'h0022);

    // Counter 10 -> 01 -> 00.
    applyStimulus(1'b1, 16'h0010, 1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    lookup("ctr00", 16'h0010, 1'b1, 1'b0, 16'h0012);

    // Five taken updates saturate at 11; last target 0x0050 overwrites.
    applyStimulus(1'b1, 16'h0010, 1'b1, 16'h0040, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    applyStimulus(1'b1, 16'h0010, 1'b1, 16'h0050, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 16'h0010, 1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    lookup("ctr10", 16'h0010, 1'b1, 1'b1, 16'h0050);
    applyStimulus(1'b1, 16'h0010, 1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    lookup("ctr01", 16'h0010, 1'b1, 1'b0, 16'h0012);

    // Aliasing on index 8: 0x0030 replaces 0x0010.
    lookup("alias_miss", 16'h0030, 1'b0, 1'b0, 16'h0032);
    applyStimulus(1'b1, 16'h0030, 1'b1, 16'h0100, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    lookup("alias_new", 16'h0030, 1'b1, 1'b1, 16'h0100);
    lookup("alias_old", 16'h0010, 1'b0, 1'b0, 16'h0012);

    // Clear beats a same-cycle allocation; the mispredict still counts.
    applyStimulus(1'b1, 16'h0020, 1'b1, 16'h0200, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    lookup("clear_30", 16'h0030, 1'b0, 1'b0, 16'h0032);
    lookup("clear_20", 16'h0020, 1'b0, 1'b0, 16'h0022);
    checkOutput("clear_cnt", 32'(bus.mispredict_cnt), 32'd1);

    lookup("wrap", 16'hFFFE, 1'b0, 1'b0, 16'h0000);

    // Unqualified mispredict is ignored.
    applyStimulus(1'b0, 16'h0020, 1'b0, 16'h0000, 1'b1, 1'b0);
    tick();
    checkOutput("unqual_cnt", 32'(bus.mispredict_cnt), 32'd1);

    // 20 qualified mispredicts from 1 saturate at 15.
    applyStimulus(1'b1, 16'h0020, 1'b0, 16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 13; i++) tick();
    checkOutput("cnt14", 32'(bus.mispredict_cnt), 32'd14);
    for (int i = 0; i < 7; i++) tick();
    checkOutput("cnt_sat", 32'(bus.mispredict_cnt), 32'd15);

    // Asynchronous reset between edges.
    applyStimulus(1'b1, 16'h0010, 1'b1, 16'h0300, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    lookup("pre_rst", 16'h0010, 1'b1, 1'b1, 16'h0300);
    #2 rst_n = 1'b0;
    #1;
    lookup("async_rst", 16'h0010, 1'b0, 1'b0, 16'h0012);
    checkOutput("async_rst_cnt", 32'(bus.mispredict_cnt), 32'd0);
    applyStimulus(1'b1, 16'h0010, 1'b1, 16'h0300, 1'b1, 1'b0);
    tick();
    lookup("rst_hold", 16'h0010, 1'b0, 1'b0, 16'h0012);
    checkOutput("rst_hold_cnt", 32'(bus.mispredict_cnt), 32'd0);
    rst_n = 1'b1;
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    lookup("post_rst", 16'h0010, 1'b1, 1'b1, 16'h0300);
    checkOutput("post_rst_cnt", 32'(bus.mispredict_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
